// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a registered one-hot grant. Define ARB_PREEMPT_EN to
// enable MAX_HOLD-based preemption of unlocked owners.
module bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               preempt
);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 preempt_q, preempt_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 lo_found, hi_found;
  logic [ID_W-1:0]      lo_idx, hi_idx, pick_idx, pick_next;
  logic [NUM_REQ-1:0]   lo_oh, hi_oh, pick_oh;
  logic                 owner_req;
  logic                 preempt_now;

  // The current owner never competes, so a release or preemption hands off to someone else.
  assign cand      = req & ~grant_q;
  assign owner_req = |(req & grant_q);

  // Scan downwards so the last hit is the lowest index; hi_* only counts hits at or above rr_ptr.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    lo_oh    = '0;
    hi_oh    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
    pick_oh  = hi_found ? hi_oh : lo_oh;
    if (32'(pick_idx) == NUM_REQ - 1) begin
      pick_next = '0;
    end else begin
      pick_next = pick_idx + 1'b1;
    end
  end

`ifdef ARB_PREEMPT_EN
  assign preempt_now = (hold_cnt_q == 8'(MAX_HOLD)) && !(|(lock & grant_q)) && lo_found;
`else
  logic unused_preempt_cfg;
  assign unused_preempt_cfg = ^{lock, 8'(MAX_HOLD)};
  assign preempt_now        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    preempt_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lo_found) begin
          state_d       = StOwned;
          grant_d       = pick_oh;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          rr_ptr_d      = pick_next;
          hold_cnt_d    = 8'd1;
        end
      end
      StOwned: begin
        if (!owner_req || preempt_now) begin
          if (lo_found) begin
            grant_d       = pick_oh;
            grant_valid_d = 1'b1;
            grant_id_d    = pick_idx;
            rr_ptr_d      = pick_next;
            hold_cnt_d    = 8'd1;
            preempt_d     = owner_req;
          end else begin
            state_d       = StIdle;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_cnt_d    = '0;
          end
        end else if (hold_cnt_q != 8'hff) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      preempt_q     <= 1'b0;
      rr_ptr_q      <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      preempt_q     <= preempt_d;
      rr_ptr_q      <= rr_ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;

endmodule
